// File: rtl/health_controller.sv
// Per-round health bookkeeping for Ryu and Akuma: hit acceptance with invulnerability,
// per-frame drain of the displayed bars, KO detection and round sequencing.
module health_controller #(
    parameter int MAX_HEALTH     = 245,
    parameter int DRAIN_STEP     = 2,
    parameter int INVULN_FRAMES  = 30,
    parameter int KO_HOLD_FRAMES = 180
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       round_start,
    input  logic       ryu_hit,
    input  logic [7:0] ryu_dmg,
    input  logic       akuma_hit,
    input  logic [7:0] akuma_dmg,
    output logic [7:0] RyuHealth,
    output logic [7:0] AkumaHealth,
    output logic       ryu_ack,
    output logic       akuma_ack,
    output logic       ko,
    output logic [1:0] winner,
    output logic       fight_active
);
    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam int HW = $clog2(KO_HOLD_FRAMES + 1);
    localparam logic [7:0]    MAX_H    = 8'(MAX_HEALTH);
    localparam logic [7:0]    STEP     = 8'(DRAIN_STEP);
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(KO_HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, FIGHT, KO_HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ryu_tgt_q, ryu_tgt_d, aku_tgt_q, aku_tgt_d;
    logic [7:0]    ryu_disp_q, ryu_disp_d, aku_disp_q, aku_disp_d;
    logic [IW-1:0] ryu_inv_q, ryu_inv_d, aku_inv_q, aku_inv_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    winner_q, winner_d;
    logic          ryu_ack_q, ryu_ack_d, aku_ack_q, aku_ack_d;
    logic          ko_q, ko_d, fight_q, fight_d;

    function automatic logic [7:0] drain(input logic [7:0] disp, input logic [7:0] tgt);
        logic [7:0] gap;
        gap = disp - tgt;
        if (disp <= tgt)     drain = disp;
        else if (gap > STEP) drain = disp - STEP;
        else                 drain = tgt;
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        sat_sub = (b >= a) ? 8'd0 : a - b;
    endfunction

    // Hits are single-cycle strobes with no back-pressure: a hit is accepted or dropped in
    // the cycle it is presented, and acceptance is reported by a one-cycle ack the next cycle.
    always_comb begin
        state_d    = state_q;
        ryu_tgt_d  = ryu_tgt_q;
        aku_tgt_d  = aku_tgt_q;
        ryu_disp_d = ryu_disp_q;
        aku_disp_d = aku_disp_q;
        ryu_inv_d  = ryu_inv_q;
        aku_inv_d  = aku_inv_q;
        hold_d     = hold_q;
        winner_d   = winner_q;
        ryu_ack_d  = 1'b0;
        aku_ack_d  = 1'b0;

        // Drain compares against the pre-hit target; a same-cycle hit lands next frame.
        if (frame_tick) begin
            ryu_disp_d = drain(ryu_disp_q, ryu_tgt_q);
            aku_disp_d = drain(aku_disp_q, aku_tgt_q);
            if (ryu_inv_q != '0) ryu_inv_d = ryu_inv_q - IW'(1);
            if (aku_inv_q != '0) aku_inv_d = aku_inv_q - IW'(1);
        end

        case (state_q)
            IDLE: begin
                if (round_start) begin
                    ryu_tgt_d  = MAX_H;
                    aku_tgt_d  = MAX_H;
                    ryu_disp_d = MAX_H;
                    aku_disp_d = MAX_H;
                    ryu_inv_d  = '0;
                    aku_inv_d  = '0;
                    winner_d   = 2'b00;
                    state_d    = FIGHT;
                end
            end
            FIGHT: begin
                if (ryu_hit && ryu_inv_q == '0) begin
                    ryu_tgt_d = sat_sub(ryu_tgt_q, ryu_dmg);
                    ryu_inv_d = INV_LOAD;
                    ryu_ack_d = 1'b1;
                end
                if (akuma_hit && aku_inv_q == '0) begin
                    aku_tgt_d = sat_sub(aku_tgt_q, akuma_dmg);
                    aku_inv_d = INV_LOAD;
                    aku_ack_d = 1'b1;
                end
                if (ryu_tgt_q == 8'd0 || aku_tgt_q == 8'd0) begin
                    state_d  = KO_HOLD;
                    hold_d   = '0;
                    winner_d = {ryu_tgt_q == 8'd0, aku_tgt_q == 8'd0};
                end
            end
            KO_HOLD: begin
                if (frame_tick && hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
                if (hold_q == HOLD_MAX && ryu_disp_q == ryu_tgt_q && aku_disp_q == aku_tgt_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ko_d    = (state_d == KO_HOLD);
        fight_d = (state_d == FIGHT);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ryu_tgt_q  <= MAX_H;
            aku_tgt_q  <= MAX_H;
            ryu_disp_q <= MAX_H;
            aku_disp_q <= MAX_H;
            ryu_inv_q  <= '0;
            aku_inv_q  <= '0;
            hold_q     <= '0;
            winner_q   <= 2'b00;
            ryu_ack_q  <= 1'b0;
            aku_ack_q  <= 1'b0;
            ko_q       <= 1'b0;
            fight_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ryu_tgt_q  <= ryu_tgt_d;
            aku_tgt_q  <= aku_tgt_d;
            ryu_disp_q <= ryu_disp_d;
            aku_disp_q <= aku_disp_d;
            ryu_inv_q  <= ryu_inv_d;
            aku_inv_q  <= aku_inv_d;
            hold_q     <= hold_d;
            winner_q   <= winner_d;
            ryu_ack_q  <= ryu_ack_d;
            aku_ack_q  <= aku_ack_d;
            ko_q       <= ko_d;
            fight_q    <= fight_d;
        end
    end

    assign RyuHealth    = ryu_disp_q;
    assign AkumaHealth  = aku_disp_q;
    assign ryu_ack      = ryu_ack_q;
    assign akuma_ack    = aku_ack_q;
    assign ko           = ko_q;
    assign winner       = winner_q;
    assign fight_active = fight_q;
endmodule

// File: tb/tb_health_controller.sv
// Bench for health_controller: a behavioural round model pushes expected outputs per cycle,
// compared after each clock edge, plus directed checks of the key scenario values.
module tb_health_controller;
    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       round_start = 1'b0;
    logic       ryu_hit = 1'b0;
    logic [7:0] ryu_dmg = 8'd0;
    logic       akuma_hit = 1'b0;
    logic [7:0] akuma_dmg = 8'd0;
    logic [7:0] RyuHealth, AkumaHealth;
    logic       ryu_ack, akuma_ack, ko, fight_active;
    logic [1:0] winner;

    always #5 vga_clk = ~vga_clk;

    health_controller dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .round_start(round_start),
        .ryu_hit(ryu_hit), .ryu_dmg(ryu_dmg), .akuma_hit(akuma_hit), .akuma_dmg(akuma_dmg),
        .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth), .ryu_ack(ryu_ack),
        .akuma_ack(akuma_ack), .ko(ko), .winner(winner), .fight_active(fight_active)
    );

    int n_checks = 0;
    int n_pass = 0;
    int fc = 0;
    logic [21:0] exp_q[$];

    // Model state: 0 idle, 1 fight, 2 KO hold.
    int m_st = 0, m_rt = 245, m_at = 245, m_rd = 245, m_ad = 245;
    int m_ri = 0, m_ai = 0, m_hold = 0, m_win = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic int drained(input int d, input int t);
        if (d <= t) return d;
        return (d - t > 2) ? d - 2 : t;
    endfunction

    task automatic model_step(input logic rst, input logic rs, input logic rh, input int rd,
                              input logic ah, input int ad, input logic ft);
        int nrt, nat, nrd, nad, nri, nai, nhold, nwin, nst;
        logic rack, aack;
        rack = 1'b0;
        aack = 1'b0;
        if (rst) begin
            m_st = 0; m_rt = 245; m_at = 245; m_rd = 245; m_ad = 245;
            m_ri = 0; m_ai = 0; m_hold = 0; m_win = 0;
        end else begin
            nrt = m_rt; nat = m_at; nrd = m_rd; nad = m_ad;
            nri = m_ri; nai = m_ai; nhold = m_hold; nwin = m_win; nst = m_st;
            if (ft) begin
                nrd = drained(m_rd, m_rt);
                nad = drained(m_ad, m_at);
                if (m_ri > 0) nri = m_ri - 1;
                if (m_ai > 0) nai = m_ai - 1;
            end
            if (m_st == 0 && rs) begin
                nrt = 245; nat = 245; nrd = 245; nad = 245;
                nri = 0; nai = 0; nwin = 0; nst = 1;
            end else if (m_st == 1) begin
                if (rh && m_ri == 0) begin
                    rack = 1'b1; nri = 30;
                    nrt = (rd >= m_rt) ? 0 : m_rt - rd;
                end
                if (ah && m_ai == 0) begin
                    aack = 1'b1; nai = 30;
                    nat = (ad >= m_at) ? 0 : m_at - ad;
                end
                if (m_rt == 0 || m_at == 0) begin
                    nst = 2; nhold = 0;
                    nwin = (m_rt == 0 && m_at == 0) ? 3 : (m_at == 0) ? 1 : 2;
                end
            end else if (m_st == 2) begin
                if (ft && m_hold < 180) nhold = m_hold + 1;
                if (m_hold == 180 && m_rd == m_rt && m_ad == m_at) nst = 0;
            end
            m_rt = nrt; m_at = nat; m_rd = nrd; m_ad = nad;
            m_ri = nri; m_ai = nai; m_hold = nhold; m_win = nwin; m_st = nst;
        end
        exp_q.push_back({m_st == 2, m_st == 1, rack, aack, 2'(m_win), 8'(m_rd), 8'(m_ad)});
    endtask

    task automatic step(input logic rst, input logic rs, input logic rh, input logic [7:0] rd,
                        input logic ah, input logic [7:0] ad);
        logic ft;
        logic [21:0] e;
        ft = (fc % 4 == 3);
        fc++;
        @(negedge vga_clk);
        Reset = rst; round_start = rs; frame_tick = ft;
        ryu_hit = rh; ryu_dmg = rd; akuma_hit = ah; akuma_dmg = ad;
        model_step(rst, rs, rh, int'(rd), ah, int'(ad), ft);
        @(posedge vga_clk);
        #1;
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("ko", ko, e[21]);
            check_eq("fight_active", fight_active, e[20]);
            check_eq("ryu_ack", ryu_ack, e[19]);
            check_eq("akuma_ack", akuma_ack, e[18]);
            check_eq("winner", winner, e[17:16]);
            check_eq("RyuHealth", RyuHealth, e[15:8]);
            check_eq("AkumaHealth", AkumaHealth, e[7:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic frames(input int n);
        idle(4 * n);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        check_eq("rst_ryu_health", RyuHealth, 245);
        check_eq("rst_akuma_health", AkumaHealth, 245);
        check_eq("rst_winner", winner, 0);
        check_eq("rst_fight", fight_active, 0);
        idle(3);

        step(1'b0, 1'b0, 1'b1, 8'd30, 1'b1, 8'd30);
        check_eq("idle_hit_no_ack", ryu_ack, 0);

        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        check_eq("start_fight", fight_active, 1);
        check_eq("start_winner", winner, 0);

        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd20);
        check_eq("aku_ack_first", akuma_ack, 1);
        frames(5);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd50);
        check_eq("aku_ack_invuln", akuma_ack, 0);
        frames(30);
        check_eq("aku_drain_225", AkumaHealth, 225);
        check_eq("ryu_untouched", RyuHealth, 245);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd50);
        check_eq("aku_ack_second", akuma_ack, 1);
        frames(40);
        check_eq("aku_drain_175", AkumaHealth, 175);

        step(1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 8'd9);
        check_eq("both_ack_ryu", ryu_ack, 1);
        check_eq("both_ack_aku", akuma_ack, 1);
        frames(40);
        check_eq("ryu_238", RyuHealth, 238);
        check_eq("aku_166", AkumaHealth, 166);

        step(1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 8'd0);
        for (int i = 0; i < 10 && ko !== 1'b1; i++) idle(1);
        check_eq("ko_ryu", ko, 1);
        check_eq("winner_akuma", winner, 2);
        step(1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 8'd5);
        check_eq("ko_no_ack", akuma_ack, 0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        check_eq("ko_ignores_start", ko, 1);
        for (int i = 0; i < 1200 && ko === 1'b1; i++) idle(1);
        check_eq("ko_released", ko, 0);
        check_eq("winner_held", winner, 2);
        check_eq("ryu_drained_0", RyuHealth, 0);
        check_eq("idle_after_ko", fight_active, 0);

        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        check_eq("r2_ryu_full", RyuHealth, 245);
        check_eq("r2_winner_clr", winner, 0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0);
        check_eq("dmg0_ack", akuma_ack, 1);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd5);
        check_eq("dmg0_invuln", akuma_ack, 0);
        frames(2);
        check_eq("dmg0_no_drain", AkumaHealth, 245);

        for (int i = 0; i < 200; i++)
            step(1'b0, 1'b0, $urandom_range(0, 7) == 0, 8'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0, 8'($urandom_range(0, 15)));
        frames(31);

        step(1'b0, 1'b0, 1'b1, 8'd255, 1'b1, 8'd255);
        for (int i = 0; i < 10 && ko !== 1'b1; i++) idle(1);
        check_eq("double_ko", ko, 1);
        check_eq("winner_double", winner, 3);
        frames(3);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        check_eq("rst_mid_ko", ko, 0);
        check_eq("rst_mid_winner", winner, 0);
        check_eq("rst_mid_ryu", RyuHealth, 245);
        check_eq("rst_mid_aku", AkumaHealth, 245);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
